// File: rtl/config_pkg.sv
// Shared configuration for vector banks: vector length, word format and index type.
// DI_t carries one spare bit so out-of-range FU addresses remain visible to the bank.
package config_pkg;
    localparam int D  = 8;
    localparam int DW = 16;
    localparam int AW = $clog2(D);

    typedef logic [DW-1:0] fixed_point_t;
    typedef logic [AW:0]   DI_t;
endpackage

// File: rtl/vector_bank_if.sv
// Bundle of the host load/drain streams and the FU start/access port of a vector bank.
interface vector_bank_if;
    import config_pkg::*;

    logic         load_valid;
    logic         load_ready;
    fixed_point_t load_data;
    logic         drain_valid;
    logic         drain_ready;
    fixed_point_t drain_data;
    logic         fu_in_ready;
    logic         fu_in_start;
    logic         fu_w_en;
    DI_t          fu_w_addr;
    fixed_point_t fu_w_data;
    DI_t          fu_r_addr;
    fixed_point_t fu_r_data;
    logic         busy;
    logic         done;

    // master: host plus functional unit; slave: the bank itself
    modport master (
        output load_valid, load_data, drain_ready, fu_in_ready,
               fu_w_en, fu_w_addr, fu_w_data, fu_r_addr,
        input  load_ready, drain_valid, drain_data, fu_in_start,
               fu_r_data, busy, done
    );
    modport slave (
        input  load_valid, load_data, drain_ready, fu_in_ready,
               fu_w_en, fu_w_addr, fu_w_data, fu_r_addr,
        output load_ready, drain_valid, drain_data, fu_in_start,
               fu_r_data, busy, done
    );
endinterface

// File: rtl/vector_mem.sv
// DEPTH-word register file: one synchronous write port, NUM_RD asynchronous read ports.
// Contents are never reset.
module vector_mem
    import config_pkg::*;
#(
    parameter int DEPTH  = D,
    parameter int NUM_RD = 1
) (
    input  logic                                    clk_i,
    input  logic                                    w_en_i,
    input  logic [$clog2(DEPTH)-1:0]                w_addr_i,
    input  fixed_point_t                            w_data_i,
    input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]    r_addr_i,
    output fixed_point_t [NUM_RD-1:0]               r_data_o
);

    fixed_point_t mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_en_i) mem[w_addr_i] <= w_data_i;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign r_data_o[g] = mem[r_addr_i[g]];
    end

endmodule

// File: rtl/vector_bank.sv
// Vector staging bank: host loads D words, hands them to a functional unit which
// rewrites them in place, then the host drains the result.
module vector_bank
    import config_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_valid_i,
    output logic         load_ready_o,
    input  fixed_point_t load_data_i,
    output logic         drain_valid_o,
    input  logic         drain_ready_i,
    output fixed_point_t drain_data_o,
    input  logic         fu_in_ready_i,
    output logic         fu_in_start_o,
    input  logic         fu_w_en_i,
    input  DI_t          fu_w_addr_i,
    input  fixed_point_t fu_w_data_i,
    input  DI_t          fu_r_addr_i,
    output fixed_point_t fu_r_data_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, DRAIN
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(D - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   load_cnt, drain_cnt;
    logic            done_q;
    logic            load_acc, drain_acc, fu_wr;
    logic            fu_w_in_range;

    logic                   mem_w_en;
    logic [AW-1:0]          mem_w_addr;
    fixed_point_t           mem_w_data;
    logic [1:0][AW-1:0]     rd_addr;
    fixed_point_t [1:0]     rd_data;

    assign fu_w_in_range = (fu_w_addr_i < DI_t'(D));

    always_comb begin
        state_d       = state_q;
        load_ready_o  = 1'b0;
        fu_in_start_o = 1'b0;
        drain_valid_o = 1'b0;
        load_acc      = 1'b0;
        drain_acc     = 1'b0;
        fu_wr         = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    load_acc = 1'b1;
                    state_d  = (load_cnt == CNT_LAST) ? START : LOAD;
                end
            end
            START: begin
                if (fu_in_ready_i) begin
                    fu_in_start_o = 1'b1;
                    state_d       = WAIT_BUSY;
                end
            end
            // FU owns the storage while it is running
            WAIT_BUSY: begin
                fu_wr = fu_w_en_i && fu_w_in_range;
                if (!fu_in_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                fu_wr = fu_w_en_i && fu_w_in_range;
                if (fu_in_ready_i) state_d = DRAIN;
            end
            DRAIN: begin
                drain_valid_o = 1'b1;
                if (drain_ready_i) begin
                    drain_acc = 1'b1;
                    if (drain_cnt == CNT_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            load_cnt  <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= drain_acc && (drain_cnt == CNT_LAST);
            if (load_acc)  load_cnt  <= load_cnt + 1'b1;
            if (drain_acc) drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // Load and FU writes live in disjoint states, so a plain 2-way mux suffices
    assign mem_w_en   = load_acc | fu_wr;
    assign mem_w_addr = load_acc ? load_cnt : fu_w_addr_i[AW-1:0];
    assign mem_w_data = load_acc ? load_data_i : fu_w_data_i;

    assign rd_addr = {drain_cnt, fu_r_addr_i[AW-1:0]};

    vector_mem #(
        .DEPTH  (D),
        .NUM_RD (2)
    ) u_mem (
        .clk_i    (clk_i),
        .w_en_i   (mem_w_en),
        .w_addr_i (mem_w_addr),
        .w_data_i (mem_w_data),
        .r_addr_i (rd_addr),
        .r_data_o (rd_data)
    );

    // Out-of-range FU reads return zero rather than aliasing onto a real word
    assign fu_r_data_o  = fu_r_addr_i[AW] ? '0 : rd_data[0];
    assign drain_data_o = rd_data[1];
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

endmodule

// File: tb/tb_vector_bank.sv
// Self-checking bench for vector_bank: word-array reference model, FU write table,
// and directed sequences for start stall, drain backpressure and mid-drain reset.
module tb_vector_bank;
    import config_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    vector_bank_if vi();

    vector_bank dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_valid_i  (vi.load_valid),
        .load_ready_o  (vi.load_ready),
        .load_data_i   (vi.load_data),
        .drain_valid_o (vi.drain_valid),
        .drain_ready_i (vi.drain_ready),
        .drain_data_o  (vi.drain_data),
        .fu_in_ready_i (vi.fu_in_ready),
        .fu_in_start_o (vi.fu_in_start),
        .fu_w_en_i     (vi.fu_w_en),
        .fu_w_addr_i   (vi.fu_w_addr),
        .fu_w_data_i   (vi.fu_w_data),
        .fu_r_addr_i   (vi.fu_r_addr),
        .fu_r_data_o   (vi.fu_r_data),
        .busy_o        (vi.busy),
        .done_o        (vi.done)
    );

    typedef struct {
        logic         en;
        DI_t          waddr;
        fixed_point_t wdata;
        DI_t          raddr;
        fixed_point_t exp;
    } fu_vec_t;

    int n_chk = 0;
    int n_err = 0;
    fixed_point_t ref_mem [D];
    fixed_point_t ld_buf  [D];
    fu_vec_t      tbl     [5];
    logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Streams ld_buf with load_valid held high; model records each accepted word.
    task automatic do_load();
        for (int k = 0; k < D; k++) begin
            vi.load_valid = 1'b1;
            vi.load_data  = ld_buf[k];
            #1;
            chk("load_ready", 32'(vi.load_ready), 32'd1);
            chk("start_during_load", 32'(vi.fu_in_start), 32'd0);
            tick();
            ref_mem[k] = ld_buf[k];
        end
        vi.load_valid = 1'b0;
    endtask

    // Enters at START; holds fu_in_ready low for 'stall' cycles, ends in WAIT_DONE.
    task automatic fu_start(input int stall);
        for (int i = 0; i < stall; i++) begin
            vi.load_valid = 1'b1;
            vi.load_data  = 16'hBAD0;
            #1;
            chk("start_stalled", 32'(vi.fu_in_start), 32'd0);
            chk("load_ready_in_start", 32'(vi.load_ready), 32'd0);
            tick();
        end
        vi.load_valid  = 1'b0;
        vi.fu_in_ready = 1'b1;
        #1;
        chk("start_pulse", 32'(vi.fu_in_start), 32'd1);
        tick();
        chk("start_after_pulse", 32'(vi.fu_in_start), 32'd0);
        chk("busy_wait", 32'(vi.busy), 32'd1);
        vi.fu_in_ready = 1'b0;
        tick();
        chk("start_wait_done", 32'(vi.fu_in_start), 32'd0);
    endtask

    // FU model: read each word, write back twice its value.
    task automatic fu_double();
        for (int k = 0; k < D; k++) begin
            vi.fu_r_addr = DI_t'(k);
            #1;
            chk("fu_read", 32'(vi.fu_r_data), 32'(ref_mem[k]));
            vi.fu_w_en   = 1'b1;
            vi.fu_w_addr = DI_t'(k);
            vi.fu_w_data = {vi.fu_r_data[DW-2:0], 1'b0};
            tick();
            ref_mem[k] = fixed_point_t'(ref_mem[k] * 2);
        end
        vi.fu_w_en = 1'b0;
    endtask

    task automatic fu_finish();
        vi.fu_in_ready = 1'b1;
        tick();
        chk("drain_entry_valid", 32'(vi.drain_valid), 32'd1);
    endtask

    // Drains D words, comparing against the model; optional 1,0,0,1 ready pattern
    // and an FU write attempt while draining.
    task automatic drain(input bit use_pat, input bit wr_in_drain);
        int got = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        fixed_point_t prev_data = '0;
        logic rdy;
        while (got < D && cyc < 100) begin
            rdy = use_pat ? pat[cyc % 4] : 1'b1;
            vi.drain_ready = rdy;
            if (wr_in_drain && cyc == 0) begin
                vi.fu_w_en   = 1'b1;
                vi.fu_w_addr = DI_t'(D - 1);
                vi.fu_w_data = 16'hABCD;
            end
            #1;
            chk("drain_valid", 32'(vi.drain_valid), 32'd1);
            chk("done_mid_drain", 32'(vi.done), 32'd0);
            if (prev_stall) chk("drain_stable", 32'(vi.drain_data), 32'(prev_data));
            if (rdy) begin
                chk("drain_word", 32'(vi.drain_data), 32'(ref_mem[got]));
                got++;
            end
            prev_stall = !rdy;
            prev_data  = vi.drain_data;
            tick();
            vi.fu_w_en = 1'b0;
            cyc++;
        end
        chk("drain_count", 32'(got), 32'(D));
        chk("done_pulse", 32'(vi.done), 32'd1);
        chk("busy_after_drain", 32'(vi.busy), 32'd0);
        chk("load_ready_on_done", 32'(vi.load_ready), 32'd1);
        chk("drain_valid_idle", 32'(vi.drain_valid), 32'd0);
        tick();
        chk("done_single", 32'(vi.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        // FU write table, applied in WAIT_DONE over contents 16'h0100*k
        tbl[0] = '{1'b1, DI_t'(3),   16'h1234, DI_t'(3), 16'h1234};
        tbl[1] = '{1'b1, DI_t'(D),   16'hDEAD, DI_t'(0), 16'h0000};
        tbl[2] = '{1'b0, DI_t'(5),   16'hBEEF, DI_t'(5), 16'h0500};
        tbl[3] = '{1'b1, DI_t'('1),  16'h7777, DI_t'(7), 16'h0700};
        tbl[4] = '{1'b1, DI_t'(3),   16'h0300, DI_t'(3), 16'h0300};

        rst_i          = 1'b1;
        vi.load_valid  = 1'b0;
        vi.load_data   = '0;
        vi.drain_ready = 1'b0;
        vi.fu_in_ready = 1'b0;
        vi.fu_w_en     = 1'b0;
        vi.fu_w_addr   = '0;
        vi.fu_w_data   = '0;
        vi.fu_r_addr   = '0;
        #3;
        chk("rst_busy", 32'(vi.busy), 32'd0);
        chk("rst_done", 32'(vi.done), 32'd0);
        chk("rst_start", 32'(vi.fu_in_start), 32'd0);
        chk("rst_drain_valid", 32'(vi.drain_valid), 32'd0);
        chk("rst_load_ready", 32'(vi.load_ready), 32'd1);
        #9 rst_i = 1'b0;
        tick();

        // A: ramp load, FU table, doubling FU, free-running drain
        for (int k = 0; k < D; k++) ld_buf[k] = fixed_point_t'(16'h0100 * k);
        vi.fu_in_ready = 1'b1;
        do_load();
        fu_start(0);
        for (int i = 0; i < 5; i++) begin
            vi.fu_w_en   = tbl[i].en;
            vi.fu_w_addr = tbl[i].waddr;
            vi.fu_w_data = tbl[i].wdata;
            vi.fu_r_addr = tbl[i].raddr;
            tick();
            vi.fu_w_en = 1'b0;
            if (tbl[i].en && tbl[i].waddr < DI_t'(D)) ref_mem[tbl[i].waddr[AW-1:0]] = tbl[i].wdata;
            chk("fu_tbl", 32'(vi.fu_r_data), 32'(tbl[i].exp));
        end
        fu_double();
        fu_finish();
        for (int k = 0; k < D; k++) chk("model_ramp", 32'(ref_mem[k]), 32'(16'h0200 * k));
        drain(1'b0, 1'b0);

        // FU write in IDLE must not land
        vi.fu_w_en   = 1'b1;
        vi.fu_w_addr = DI_t'(2);
        vi.fu_w_data = 16'hFFFF;
        vi.fu_r_addr = DI_t'(2);
        tick();
        vi.fu_w_en = 1'b0;
        chk("fu_write_idle", 32'(vi.fu_r_data), 32'h0400);

        // B: random load, stalled start, backpressured drain, FU write in DRAIN
        for (int k = 0; k < D; k++) ld_buf[k] = fixed_point_t'($urandom);
        vi.fu_in_ready = 1'b0;
        do_load();
        fu_start(5);
        fu_double();
        fu_finish();
        drain(1'b1, 1'b1);

        // C: reset mid-drain
        for (int k = 0; k < D; k++) ld_buf[k] = fixed_point_t'($urandom);
        vi.fu_in_ready = 1'b1;
        do_load();
        fu_start(0);
        fu_finish();
        for (int i = 0; i < 2; i++) begin
            vi.drain_ready = 1'b1;
            #1;
            chk("partial_drain", 32'(vi.drain_data), 32'(ref_mem[i]));
            tick();
        end
        vi.drain_ready = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_drain_valid", 32'(vi.drain_valid), 32'd0);
        chk("rst_async_busy", 32'(vi.busy), 32'd0);
        chk("rst_async_load_ready", 32'(vi.load_ready), 32'd1);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_done_after_rst", 32'(vi.done), 32'd0);
            chk("idle_after_rst", 32'(vi.busy), 32'd0);
        end

        // D: fresh random operation after reset
        for (int k = 0; k < D; k++) ld_buf[k] = fixed_point_t'($urandom);
        do_load();
        fu_start(0);
        fu_double();
        fu_finish();
        drain(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
